// File: rtl/hwpe_stream_tcdm_responder_pkg.sv
// Shared definitions for the TCDM responder: write-enable encoding,
// latency bound and the response pipeline stage layout.
package hwpe_stream_package;

    // wen=1 marks a read on the TCDM bus
    localparam logic HWPE_TCDM_WEN_READ = 1'b1;

    // deepest response pipeline the responder supports
    localparam int unsigned TCDM_RESP_MAX_LATENCY = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
    } tcdm_resp_stage_t;

endpackage

// File: rtl/hwpe_stream_tcdm_resp_pipe.sv
// LATENCY-deep {valid, rdata} shift register carrying TCDM responses.
// Non-valid stages always hold zero data so r_data is 0 when r_valid is 0.
module hwpe_stream_tcdm_resp_pipe
    import hwpe_stream_package::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        valid_in,
    input  logic [31:0] rdata_in,
    output logic        valid_out,
    output logic [31:0] rdata_out
);

    tcdm_resp_stage_t stage_q [LATENCY];

    // shift responses toward the output; reset/clear drops everything in flight
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < LATENCY; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q[0].valid <= valid_in;
            stage_q[0].rdata <= valid_in ? rdata_in : 32'h0;
            for (int i = 1; i < LATENCY; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign valid_out = stage_q[LATENCY-1].valid;
    assign rdata_out = stage_q[LATENCY-1].valid ? stage_q[LATENCY-1].rdata : 32'h0;

endmodule

// File: rtl/hwpe_stream_tcdm_responder.sv
// Memory-side TCDM endpoint: word-addressed storage with byte enables,
// same-cycle grant and a fixed-latency response for every accepted request.
// Optional random grant stalls: define HWPE_STREAM_TCDM_RESPONDER_STALL_EN.
module hwpe_stream_tcdm_responder
    import hwpe_stream_package::*;
#(
    parameter int unsigned NB_WORDS     = 1024,
    parameter int unsigned LATENCY      = 1,
    parameter int unsigned STALL_PERIOD = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        tcdm_req,
    output logic        tcdm_gnt,
    input  logic [31:0] tcdm_add,
    input  logic        tcdm_wen,
    input  logic [3:0]  tcdm_be,
    input  logic [31:0] tcdm_data,
    output logic [31:0] tcdm_r_data,
    output logic        tcdm_r_valid,
    output logic [31:0] n_reads_o,
    output logic [31:0] n_writes_o
);

    localparam int unsigned IDX_W = $clog2(NB_WORDS);

    if (LATENCY < 1 || LATENCY > TCDM_RESP_MAX_LATENCY || NB_WORDS < 2 ||
        (NB_WORDS & (NB_WORDS - 1)) != 0 || STALL_PERIOD < 2 ||
        (STALL_PERIOD & (STALL_PERIOD - 1)) != 0) begin : g_bad_param
        $error("hwpe_stream_tcdm_responder: illegal parameter set");
    end

    logic [31:0]      mem [NB_WORDS];
    logic [IDX_W-1:0] idx;
    logic             stall;
    logic             accept;
    logic             is_read;
    logic             unused_add_bits;

    // byte offset and bits above the array depth are ignored: addresses wrap
    assign idx             = tcdm_add[2 +: IDX_W];
    assign unused_add_bits = ^{tcdm_add[1:0], tcdm_add[31:IDX_W+2]};

`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
    localparam int unsigned STALL_W = $clog2(STALL_PERIOD);

    logic [15:0] lfsr_q;

    // free-running x^16+x^14+x^13+x^11+1 LFSR; only reset reseeds it
    always_ff @(posedge clk_i) begin
        if (rst_i)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    assign stall = (lfsr_q[STALL_W-1:0] == '0);
`else
    assign stall = 1'b0;
`endif

    // zero-wait grant, withheld during reset/clear so nothing is accepted then
    assign tcdm_gnt = tcdm_req & ~stall & ~clear_i & ~rst_i;
    assign accept   = tcdm_req & tcdm_gnt;
    assign is_read  = (tcdm_wen == HWPE_TCDM_WEN_READ);

    // byte-enabled write; storage is never reset
    always_ff @(posedge clk_i) begin
        if (accept && !is_read) begin
            for (int b = 0; b < 4; b++)
                if (tcdm_be[b])
                    mem[idx][8*b +: 8] <= tcdm_data[8*b +: 8];
        end
    end

    hwpe_stream_tcdm_resp_pipe #(
        .LATENCY (LATENCY)
    ) i_resp_pipe (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (clear_i),
        .valid_in  (accept),
        .rdata_in  (is_read ? mem[idx] : 32'h0),
        .valid_out (tcdm_r_valid),
        .rdata_out (tcdm_r_data)
    );

    // saturating transaction counters
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            n_reads_o  <= '0;
            n_writes_o <= '0;
        end else if (accept) begin
            if (is_read && n_reads_o != '1)
                n_reads_o <= n_reads_o + 32'd1;
            if (!is_read && n_writes_o != '1)
                n_writes_o <= n_writes_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_tcdm_responder.sv
// Directed bench for the TCDM responder: three instances (latency 1/2/3,
// the latency-1 one with a 16-word array) share the request bus.
module tb_hwpe_stream_tcdm_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        req = 1'b0;
    logic [31:0] add = '0;
    logic        wen = 1'b1;
    logic [3:0]  be = '0;
    logic [31:0] data = '0;

    logic        gnt1, gnt2, gnt3, rv1, rv2, rv3;
    logic [31:0] rd1, rd2, rd3, nr1, nr2, nr3, nw1, nw2, nw3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hwpe_stream_tcdm_responder #(.NB_WORDS(16), .LATENCY(1), .STALL_PERIOD(4)) u_l1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm_req(req), .tcdm_gnt(gnt1),
        .tcdm_add(add), .tcdm_wen(wen), .tcdm_be(be), .tcdm_data(data),
        .tcdm_r_data(rd1), .tcdm_r_valid(rv1), .n_reads_o(nr1), .n_writes_o(nw1));

    hwpe_stream_tcdm_responder #(.NB_WORDS(1024), .LATENCY(2), .STALL_PERIOD(4)) u_l2 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm_req(req), .tcdm_gnt(gnt2),
        .tcdm_add(add), .tcdm_wen(wen), .tcdm_be(be), .tcdm_data(data),
        .tcdm_r_data(rd2), .tcdm_r_valid(rv2), .n_reads_o(nr2), .n_writes_o(nw2));

    hwpe_stream_tcdm_responder #(.NB_WORDS(1024), .LATENCY(3), .STALL_PERIOD(4)) u_l3 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .tcdm_req(req), .tcdm_gnt(gnt3),
        .tcdm_add(add), .tcdm_wen(wen), .tcdm_be(be), .tcdm_data(data),
        .tcdm_r_data(rd3), .tcdm_r_valid(rv3), .n_reads_o(nr3), .n_writes_o(nw3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        req = r; wen = w; add = a; be = b; data = d;
        #1;
    endtask

    task automatic pulse_clear();
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
        tick(); tick();
        checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b, expected 0", gnt1); end
        checks++; if (rv1 !== 1'b0 || rd1 !== 32'h0) begin errors++; $display("FAIL reset_resp: got %b/%h, expected 0/0", rv1, rd1); end
        checks++; if (nr3 !== 32'h0 || nw3 !== 32'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h, expected 0/0", nr3, nw3); end
        rst = 1'b0;
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick();
        checks++; if (rv2 !== 1'b0) begin errors++; $display("FAIL reset_idle_rv: got %b, expected 0", rv2); end
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF);
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b, expected 1", gnt1); end
        tick();
        checks++; if (rv1 !== 1'b1 || rd1 !== 32'h0) begin errors++; $display("FAIL wr_resp: got %b/%h, expected 1/0", rv1, rd1); end
        drive(1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b, expected 1", gnt1); end
        tick();
        checks++; if (rv1 !== 1'b1 || rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_resp: got %b/%h, expected 1/deadbeef", rv1, rd1); end
        checks++; if (nw1 !== 32'd1 || nr1 !== 32'd1) begin errors++; $display("FAIL wr_rd_cnt: got w%0d r%0d, expected w1 r1", nw1, nr1); end
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick();
        checks++; if (rv1 !== 1'b0 || rd1 !== 32'h0) begin errors++; $display("FAIL idle_resp: got %b/%h, expected 0/0", rv1, rd1); end
    endtask

    task automatic test_partial_write();
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h11223344);
        tick();
        drive(1'b1, 1'b0, 32'h10, 4'b0101, 32'hAABBCCDD);
        tick();
        checks++; if (rv1 !== 1'b1 || rd1 !== 32'h0) begin errors++; $display("FAIL pw_wr_resp: got %b/%h, expected 1/0", rv1, rd1); end
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'hFFFFFFFF);
        tick();
        drive(1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
        tick();
        checks++; if (rv1 !== 1'b1 || rd1 !== 32'h11BB33DD) begin errors++; $display("FAIL pw_rd: got %b/%h, expected 1/11bb33dd", rv1, rd1); end
        checks++; if (nw1 !== 32'd4 || nr1 !== 32'd2) begin errors++; $display("FAIL pw_cnt: got w%0d r%0d, expected w4 r2", nw1, nr1); end
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick();
    endtask

    task automatic test_back_to_back();
        int nvalid;
        pulse_clear();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, k * 4, 4'hF, 32'h10000000 + k * 32'h111);
            tick();
        end
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick(); tick(); tick();
        nvalid = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 8) drive(1'b1, 1'b1, c * 4, 4'h0, 32'h0);
            else       drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
            tick();
            if (rv3 === 1'b1) nvalid++;
            if (c >= 2 && c < 10) begin
                checks++;
                if (rv3 !== 1'b1 || rd3 !== 32'h10000000 + (c - 2) * 32'h111) begin
                    errors++; $display("FAIL b2b_rd%0d: got %b/%h, expected 1/%h", c - 2, rv3, rd3, 32'h10000000 + (c - 2) * 32'h111);
                end
            end else begin
                checks++;
                if (rv3 !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: got rv %b, expected 0", c, rv3); end
            end
        end
        checks++; if (nvalid != 8) begin errors++; $display("FAIL b2b_count: got %0d, expected 8", nvalid); end
        checks++; if (nr3 !== 32'd8 || nw3 !== 32'd8) begin errors++; $display("FAIL b2b_cnt: got r%0d w%0d, expected r8 w8", nr3, nw3); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 32'h40, 4'hF, 32'h5);
        tick();
        drive(1'b1, 1'b1, 32'h0, 4'h0, 32'h0);
        tick();
        checks++; if (rv1 !== 1'b1 || rd1 !== 32'h5) begin errors++; $display("FAIL wrap_rd: got %b/%h, expected 1/5", rv1, rd1); end
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick(); tick();
        checks++; if (rv3 !== 1'b1 || rd3 !== 32'h10000000) begin errors++; $display("FAIL nowrap_rd: got %b/%h, expected 1/10000000", rv3, rd3); end
        tick();
    endtask

    task automatic test_clear();
        pulse_clear();
        drive(1'b1, 1'b1, 32'h8, 4'h0, 32'h0);
        checks++; if (gnt2 !== 1'b1) begin errors++; $display("FAIL clr_first_gnt: got %b, expected 1", gnt2); end
        tick();
        clear = 1'b1;
        #1;
        checks++; if (gnt2 !== 1'b0) begin errors++; $display("FAIL clr_gnt: got %b, expected 0", gnt2); end
        tick();
        clear = 1'b0;
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        checks++; if (rv2 !== 1'b0 || rd2 !== 32'h0) begin errors++; $display("FAIL clr_drop: got %b/%h, expected 0/0", rv2, rd2); end
        checks++; if (nr2 !== 32'd0 || nw2 !== 32'd0) begin errors++; $display("FAIL clr_cnt: got r%0d w%0d, expected r0 w0", nr2, nw2); end
        tick();
        checks++; if (rv2 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL clr_late: got %b/%b, expected 0/0", rv2, rv3); end
        checks++; if (nr2 !== 32'd0) begin errors++; $display("FAIL clr_held_req: got r%0d, expected r0", nr2); end
    endtask

    task automatic test_continuous(input int ncyc);
        int ngnt, nrv, k;
        logic g, got;
        pulse_clear();
        ngnt = 0; nrv = 0; k = 0;
        for (int c = 0; c < ncyc; c++) begin
            drive(1'b1, 1'b0, (k % 16) * 4, 4'hF, 32'hC0000000 + k);
            g = gnt1;
            tick();
            if (g) begin ngnt++; k++; end
            if (rv1 === 1'b1) nrv++;
        end
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        tick();
        if (rv1 === 1'b1) nrv++;
`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
        checks++; if (ncyc - ngnt < 210 || ncyc - ngnt > 290) begin errors++; $display("FAIL stall_rate: got %0d stalls, expected 210..290", ncyc - ngnt); end
`else
        checks++; if (ngnt != ncyc) begin errors++; $display("FAIL cont_gnt: got %0d, expected %0d", ngnt, ncyc); end
`endif
        checks++; if (nrv != ngnt) begin errors++; $display("FAIL cont_rvalid: got %0d, expected %0d", nrv, ngnt); end
        checks++; if (nw1 !== ngnt) begin errors++; $display("FAIL cont_writes: got %0d, expected %0d", nw1, ngnt); end
        got = 1'b0;
        for (int w = 0; w < 32 && !got; w++) begin
            drive(1'b1, 1'b1, ((k - 1) % 16) * 4, 4'h0, 32'h0);
            got = gnt1;
            tick();
        end
        drive(1'b0, 1'b1, 32'h0, 4'h0, 32'h0);
        checks++;
        if (!got || rv1 !== 1'b1 || rd1 !== 32'hC0000000 + k - 1) begin
            errors++; $display("FAIL cont_last: got %b/%h, expected 1/%h", rv1, rd1, 32'hC0000000 + k - 1);
        end
    endtask

    initial begin
        test_reset();
`ifdef HWPE_STREAM_TCDM_RESPONDER_STALL_EN
        test_continuous(1000);
`else
        test_write_read();
        test_partial_write();
        test_back_to_back();
        test_wrap();
        test_clear();
        test_continuous(200);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
